i2c_req_arbiter: RTL
====================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, SHALL be the number of WAIT_DONE cycles before a transaction is aborted (range 2..2^20).
REQ-002 clk  input  1  SHALL be the single clock (the divided I2C-side clock); all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  SHALL be the per-requester transaction requests.
REQ-005 rw0, rw1  input  1 each  SHALL select the direction: 1 = read, 0 = write.
REQ-006 addr0, addr1  input  7 each  SHALL be the 7-bit slave addresses.
REQ-007 wdata0, wdata1  input  8 each  SHALL be the write data bytes.
REQ-008 gnt0, gnt1  output  1 each  SHALL be the one-cycle command-accepted pulses.
REQ-009 done0, done1  output  1 each  SHALL be the one-cycle completion pulses.
REQ-010 rdata  output  8  SHALL carry the read byte; nack output 1 SHALL flag a slave NACK; tmo output 1 SHALL flag a timeout. All three are shared by both requesters.
REQ-011 m_start  output  1, m_rw  output  1, m_addr  output  7, m_wdata  output  8  SHALL form the command port to the I2C master.
REQ-012 m_busy  input  1, m_done  input  1 (pulse), m_rdata  input  8, m_nack  input  1  SHALL form the master status port.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE and COMPLETE. All outputs SHALL be registered.
REQ-014 In IDLE, if (req0|req1) and !m_busy, the block SHALL select a winner and latch that requester's rw/addr/wdata into m_rw/m_addr/m_wdata. The next state SHALL be ISSUE.
REQ-015 Arbitration SHALL be round-robin on a last_grant bit. If only one request is active, that requester wins. If both are active, the requester other than last_grant wins.
REQ-016 In ISSUE, the winner's gnt and m_start SHALL both be high for exactly one cycle. The next state SHALL be WAIT_DONE.
REQ-017 Latency: a request sampled in IDLE at edge N SHALL produce gnt/m_start in the cycle after edge N (one-cycle latency).
REQ-018 In WAIT_DONE, a 20-bit counter SHALL increment each cycle, starting from 0.
  - On m_done: capture rdata<=m_rdata, nack<=m_nack, tmo<=0, then go to COMPLETE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no m_done: rdata<=0, nack<=0, tmo<=1, then go to COMPLETE.
  - If m_done and expiry coincide, m_done SHALL win.
REQ-019 In COMPLETE, the winner's done SHALL be high for one cycle, last_grant SHALL be updated to the winner, the counter SHALL be cleared, and the next state SHALL be IDLE.
REQ-020 rdata/nack/tmo SHALL hold their values until the next COMPLETE.
REQ-021 m_done SHALL be ignored outside WAIT_DONE. The req inputs SHALL be ignored outside IDLE.
REQ-022 Requester rules:
  - A requester SHALL hold req and its command stable until its gnt.
  - Dropping req before gnt SHALL cancel the request with no side effect.
  - req still high after done SHALL be treated as a new request.
REQ-023 m_busy high in IDLE SHALL stall arbitration. Nothing is granted while it is high.
REQ-024 m_rw, m_addr and m_wdata SHALL remain stable from ISSUE through COMPLETE.

Reset
REQ-025 On reset, the block SHALL apply:
  - state = IDLE;
  - last_grant = 1, so requester 0 wins the first tie;
  - counter = 0;
  - all outputs = 0 (gnt*, done*, m_start, m_rw, m_addr, m_wdata, rdata, nack, tmo).
REQ-026 Reset asserted in any state SHALL abort the transaction with no done pulse. It SHALL take priority over every other event in the same cycle.

Verification
REQ-027 Single write: req0=1, rw0=0, addr0=7'h48, wdata0=8'hA5; m_done after 50 cycles with m_nack=0 -> expect:
  - gnt0 and m_start one-cycle pulse, with m_addr=7'h48, m_wdata=8'hA5;
  - done0 pulse, then nack=0, tmo=0.
REQ-028 Read: req1=1, rw1=1, addr1=7'h1D; m_rdata=8'h3C on m_done -> expect done1 pulse and rdata=8'h3C.
REQ-029 Contention after reset: req0 and req1 both held high continuously -> expect grant order 0, 1, 0, 1, each gnt only after the previous done.
REQ-030 Timeout: TIMEOUT_CYCLES=16, m_done never asserted -> expect done0 exactly 16 WAIT_DONE cycles after m_start, with tmo=1 and rdata=8'h00.
REQ-031 Stall and abort:
  - m_busy=1 with req0=1 -> expect no gnt until m_busy falls.
  - Reset pulsed during WAIT_DONE -> expect no done pulse, all outputs 0, then a fresh req0 grants normally.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sharing one I2C master between two requesters, with done timeout.
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       nack,
  output logic       tmo,
  output logic       m_start,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic [7:0] m_rdata,
  input  logic       m_nack
);
  localparam logic [19:0] LIM = 20'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;
  state_t state, nxt;
  logic last, win, win_n, start, fin;
  logic [19:0] cnt;
  assign start = state == IDLE && (req0 | req1) && !m_busy;
  assign win_n = (req0 & req1) ? ~last : req1;
  // m_done is checked first, so it wins when it coincides with expiry
  assign fin = state == WAIT_DONE && (m_done || cnt == LIM);
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb
    nxt = state == IDLE      ? (start ? ISSUE : IDLE) :
          state == ISSUE     ? WAIT_DONE :
          state == WAIT_DONE ? (fin ? COMPLETE : WAIT_DONE) : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      {gnt0, gnt1, done0, done1, m_start, m_rw, nack, tmo} <= '0;
      {m_addr, m_wdata, rdata} <= '0;
      last <= 1'b1;
      win <= 1'b0;
      cnt <= '0;
    end else begin
      gnt0 <= start && !win_n;
      gnt1 <= start && win_n;
      m_start <= start;
      done0 <= fin && !win;
      done1 <= fin && win;
      cnt <= state == WAIT_DONE ? cnt + 20'd1 : '0;
      if (start) begin
        win <= win_n;
        m_rw <= win_n ? rw1 : rw0;
        m_addr <= win_n ? addr1 : addr0;
        m_wdata <= win_n ? wdata1 : wdata0;
      end
      if (fin) begin
        rdata <= m_done ? m_rdata : 8'h00;
        nack <= m_done && m_nack;
        tmo <= !m_done;
      end
      if (state == COMPLETE) last <= win;
    end
  end
endmodule
